lut_eval_pipe: RTL and testbench

- Parametrised, registered N-input Boolean function evaluator. It is the sequential successor to the fixed 5-input combinational test functions.
- The function is a runtime-loadable truth table (LUT) of 2^N_IN bits, loaded serially.
- Input vectors are evaluated through a valid/ready pipeline stage.
- A gated, saturating hit counter records how many evaluated vectors returned 1. It is used as a self-checking stimulus/monitor block in the test area.

---
 rtl/lut_eval_pipe.sv | 71 +++++++
 tb/tb_lut_eval_pipe.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lut_eval_pipe.sv
// lut_eval_pipe: serially loadable N-input LUT evaluator with a valid/ready output stage and a saturating hit counter
module lut_eval_pipe #(
  parameter int N_IN = 5,
  parameter logic [2**N_IN-1:0] LUT_INIT = '0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_y,
  input  logic             out_ready,
  input  logic             cfg_start,
  input  logic             cfg_bit_valid,
  input  logic             cfg_bit,
  output logic             busy,
  output logic             cfg_done,
  input  logic             cnt_en,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hit_cnt
);
  localparam int DEPTH = 2**N_IN;
  typedef enum logic {RUN, LOAD} state_t;
  state_t state_q, state_d;
  logic [DEPTH-1:0] lut_q;
  logic [N_IN-1:0] idx_q;
  logic [CNT_W-1:0] hit_q;
  logic out_valid_q, out_y_q, cfg_done_q;
  logic load_go, last, accept, xfer;
  always_comb begin
    load_go  = state_q == RUN && cfg_start && !out_valid_q;
    last     = state_q == LOAD && cfg_bit_valid && &idx_q;
    in_ready = state_q == RUN && !cfg_start && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;
    xfer     = out_valid_q && out_ready;
    state_d  = load_go ? LOAD : last ? RUN : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      lut_q       <= LUT_INIT;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= 1'b0;
      cfg_done_q  <= 1'b0;
      hit_q       <= '0;
    end else begin
      state_q    <= state_d;
      cfg_done_q <= last;
      if (load_go) idx_q <= '0;
      else if (state_q == LOAD && cfg_bit_valid) begin
        lut_q[idx_q] <= cfg_bit;
        idx_q        <= idx_q + N_IN'(1);
      end
      if (accept) begin
        out_y_q     <= lut_q[in_data];
        out_valid_q <= 1'b1;
      end else if (xfer) out_valid_q <= 1'b0;
      // clear wins over increment; counter sticks at all-ones
      if (cnt_clr) hit_q <= '0;
      else if (xfer && out_y_q && cnt_en && !(&hit_q)) hit_q <= hit_q + CNT_W'(1);
    end
  end
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign busy      = state_q == LOAD;
  assign cfg_done  = cfg_done_q;
  assign hit_cnt   = hit_q;
endmodule

// File: tb/tb_lut_eval_pipe.sv
// tb_lut_eval_pipe: table-driven directed tests plus randomized traffic against a spec-level model
module tb_lut_eval_pipe;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, cfg_start = 0;
  logic cfg_bit_valid = 0, cfg_bit = 0, cnt_en = 1, cnt_clr = 0;
  logic [4:0] in_data = '0;
  logic in_ready, out_valid, out_y, busy, cfg_done;
  logic in_ready2, out_valid2, out_y2, busy2, cfg_done2;
  logic [7:0] hit_cnt;
  logic [1:0] hit_cnt2;
  int checks = 0, errors = 0, done_cnt = 0;

  always #5 clk = ~clk;

  lut_eval_pipe #(.N_IN(5), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_y(out_y), .out_ready(out_ready), .cfg_start(cfg_start),
    .cfg_bit_valid(cfg_bit_valid), .cfg_bit(cfg_bit), .busy(busy), .cfg_done(cfg_done),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt));

  lut_eval_pipe #(.N_IN(5), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_y(out_y2), .out_ready(out_ready), .cfg_start(cfg_start),
    .cfg_bit_valid(cfg_bit_valid), .cfg_bit(cfg_bit), .busy(busy2), .cfg_done(cfg_done2),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt2));

  // reference model: truth table as a bit array, a single result slot, integer counters
  bit m_lut[32];
  bit m_busy, m_ov, m_oy, m_done;
  int m_idx, m_cnt, m_cnt2;

  typedef struct {logic [4:0] v; logic y;} vec_t;
  vec_t tbl[10];
  int sat_seq[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    foreach (m_lut[i]) m_lut[i] = 1'b0;
    m_busy = 0; m_ov = 0; m_oy = 0; m_done = 0; m_idx = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  // one clock: check in_ready, advance model across the edge, check registered outputs
  task automatic step();
    bit rdy, xfer;
    #1;
    rdy = !m_busy && !cfg_start && (!m_ov || out_ready);
    chk("in_ready", in_ready, rdy);
    @(posedge clk);
    if (rst) m_reset();
    else begin
      xfer = m_ov && out_ready;
      if (cnt_clr) begin m_cnt = 0; m_cnt2 = 0; end
      else if (xfer && m_oy && cnt_en) begin
        m_cnt  = m_cnt  < 255 ? m_cnt  + 1 : 255;
        m_cnt2 = m_cnt2 < 3   ? m_cnt2 + 1 : 3;
      end
      m_done = 0;
      if (m_busy) begin
        if (cfg_bit_valid) begin
          m_lut[m_idx] = cfg_bit;
          m_idx++;
          if (m_idx == 32) begin m_busy = 0; m_done = 1; end
        end
      end else if (cfg_start && !m_ov) begin m_busy = 1; m_idx = 0; end
      if (in_valid && rdy) begin m_oy = m_lut[in_data]; m_ov = 1; end
      else if (xfer) m_ov = 0;
    end
    #1;
    if (cfg_done === 1'b1) done_cnt++;
    chk("out_valid", out_valid, m_ov);
    chk("out_y", out_y, m_oy);
    chk("busy", busy, m_busy);
    chk("cfg_done", cfg_done, m_done);
    chk("hit_cnt", hit_cnt, m_cnt);
    chk("hit_cnt2", hit_cnt2, m_cnt2);
    @(negedge clk);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      in_valid = 1; in_data = tbl[i].v;
      step();
      chk($sformatf("tbl%0d", i), out_y, tbl[i].y);
    end
    in_valid = 0;
    step();
  endtask

  task automatic load(input logic [31:0] val, input int nbits);
    int c = 0;
    in_valid = 0; out_ready = 1;
    step();
    cfg_start = 1;
    step();
    cfg_start = 0;
    for (int i = 0; i < nbits; c++) begin
      cfg_bit_valid = (c % 3) != 2;
      cfg_bit = val[i];
      if (cfg_bit_valid) i++;
      step();
    end
    cfg_bit_valid = 0;
  endtask

  initial begin
    tbl[0] = '{5'b00000, 1'b0}; tbl[1] = '{5'b10101, 1'b0}; tbl[2] = '{5'b11111, 1'b0};
    tbl[3] = '{5'b00000, 1'b0}; tbl[4] = '{5'b10101, 1'b1}; tbl[5] = '{5'b11011, 1'b0};
    tbl[6] = '{5'b11111, 1'b1};
    tbl[7] = '{5'b01010, 1'b0}; tbl[8] = '{5'b11100, 1'b0}; tbl[9] = '{5'b11111, 1'b1};
    sat_seq = '{1, 2, 3, 3, 3};
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    rst = 0;
    // 1: default table evaluates to zero
    run_vecs(0, 2);
    chk("t1_hit", hit_cnt, 0);
    // 2: gapped load of bits 21 and 31
    done_cnt = 0;
    load(32'h8020_0000, 32);
    step();
    chk("t2_done_pulses", done_cnt, 1);
    run_vecs(3, 6);
    chk("t2_hit", hit_cnt, 2);
    // 3: gated counter, then clear
    cnt_en = 0;
    run_vecs(7, 9);
    chk("t3_hit_frozen", hit_cnt, 2);
    cnt_en = 1; cnt_clr = 1;
    step();
    cnt_clr = 0;
    chk("t3_hit_clr", hit_cnt, 0);
    // 4: backpressure with ignored cfg_start
    in_valid = 1; in_data = 5'b10101; out_ready = 0;
    step();
    in_data = 5'b00000;
    for (int i = 0; i < 3; i++) begin
      cfg_start = i == 1;
      step();
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_y", out_y, 1);
      chk("t4_no_load", busy, 0);
    end
    cfg_start = 0; in_valid = 0; out_ready = 1;
    step();
    // 5: 2-bit counter saturation
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    in_valid = 1; in_data = 5'b11111;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t5_sat%0d", i), hit_cnt2, sat_seq[i]);
    end
    in_valid = 0;
    step();
    // 6: reset mid-load discards the partial table
    load(32'hFFFF_FFFF, 10);
    rst = 1;
    step();
    rst = 0;
    chk("t6_busy", busy, 0);
    chk("t6_done", cfg_done, 0);
    chk("t6_hit", hit_cnt, 0);
    in_valid = 1; in_data = 5'b10101;
    step();
    chk("t6_y", out_y, 0);
    in_valid = 0;
    step();
    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst           = ($urandom % 400) == 0;
      in_valid      = $urandom % 2;
      in_data       = 5'($urandom);
      out_ready     = ($urandom % 4) != 0;
      cnt_en        = ($urandom % 8) != 0;
      cnt_clr       = ($urandom % 120) == 0;
      cfg_start     = ($urandom % 30) == 0;
      cfg_bit_valid = ($urandom % 3) != 0;
      cfg_bit       = $urandom % 2;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
